// File: rtl/lib_edge_flg_bank.sv
// lib_edge_flg_bank: per-channel synchronised edge detector with event pulse, sticky flag,
// saturating counter and capture of the first channel to flag since all flags were clear
module lib_edge_flg_bank #(
    parameter int NCH         = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8,
    localparam int CHW        = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NCH-1:0]       data_i,
    input  logic [2*NCH-1:0]     mode_i,
    input  logic [NCH-1:0]       clr_i,
    output logic [NCH-1:0]       pulse_o,
    output logic [NCH-1:0]       flg_o,
    output logic [NCH*CNT_W-1:0] cnt_o,
    output logic                 any_flg_o,
    output logic                 first_vld_o,
    output logic [CHW-1:0]       first_ch_o
);
    localparam logic [2:0] WU = 3'(SYNC_STAGES + 1);

    logic [NCH-1:0]   w_s;
    logic [NCH-1:0]   w_ev;
    logic [NCH-1:0]   w_flg_nxt;
    logic [CHW-1:0]   w_low;
    logic             w_primed;
    logic [NCH-1:0]   r_prev;
    logic [NCH-1:0]   r_pulse;
    logic [NCH-1:0]   r_flg;
    logic [CNT_W-1:0] r_cnt [NCH];
    logic             r_any;
    logic             r_vld;
    logic [CHW-1:0]   r_ch;
    logic [2:0]       r_wu;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign w_s = data_i;
        end else begin : g_sync
            logic [NCH-1:0] r_sync [SYNC_STAGES];
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
                end else begin
                    r_sync[0] <= data_i;
                    for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
                end
            end
            assign w_s = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    // Edges are ignored until the reset zeros have been flushed out of the synchroniser
    assign w_primed  = (r_wu == WU);
    assign w_flg_nxt = w_ev | (r_flg & ~clr_i);

    always_comb begin
        w_ev  = '0;
        w_low = '0;
        for (int n = 0; n < NCH; n++)
            w_ev[n] = w_primed & ((mode_i[2*n] & ~r_prev[n] & w_s[n]) | (mode_i[2*n+1] & r_prev[n] & ~w_s[n]));
        for (int n = NCH - 1; n >= 0; n--)
            if (w_ev[n]) w_low = CHW'(n);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wu    <= '0;
            r_prev  <= '0;
            r_pulse <= '0;
            r_flg   <= '0;
            r_any   <= 1'b0;
            r_vld   <= 1'b0;
            r_ch    <= '0;
            for (int n = 0; n < NCH; n++) r_cnt[n] <= '0;
        end else begin
            r_wu    <= w_primed ? r_wu : r_wu + 3'd1;
            r_prev  <= w_s;
            r_pulse <= w_ev;
            r_flg   <= w_flg_nxt;
            r_any   <= |w_flg_nxt;
            for (int n = 0; n < NCH; n++) begin
                if (clr_i[n])
                    r_cnt[n] <= CNT_W'(w_ev[n]);
                else if (w_ev[n] && r_cnt[n] != '1)
                    r_cnt[n] <= r_cnt[n] + CNT_W'(1);
            end
            // Capture survives a clear that coincides with a new event
            if (w_flg_nxt == '0) begin
                r_vld <= 1'b0;
            end else if (!r_vld && w_ev != '0) begin
                r_vld <= 1'b1;
                r_ch  <= w_low;
            end
        end
    end

    generate
        for (genvar g = 0; g < NCH; g++) begin : g_cnt
            assign cnt_o[g*CNT_W +: CNT_W] = r_cnt[g];
        end
    endgenerate

    assign pulse_o     = r_pulse;
    assign flg_o       = r_flg;
    assign any_flg_o   = r_any;
    assign first_vld_o = r_vld;
    assign first_ch_o  = r_ch;
endmodule

// File: tb/tb_lib_edge_flg_bank.sv
// tb_lib_edge_flg_bank: scoreboard bench; a history-based reference model predicts every output per cycle
module tb_lib_edge_flg_bank;
    localparam int NCH = 4;
    localparam int S   = 2;
    localparam int CW  = 8;
    localparam int OW  = 2*NCH + NCH*CW + 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic [3:0]    data_i = '0;
    logic [7:0]    mode_i = '0;
    logic [3:0]    clr_i = '0;
    logic [3:0]    pulse_o;
    logic [3:0]    flg_o;
    logic [31:0]   cnt_o;
    logic          any_flg_o;
    logic          first_vld_o;
    logic [1:0]    first_ch_o;

    int            total = 0;
    int            bad = 0;
    int            ecount = 0;
    logic [3:0]    hist[$];
    logic [OW-1:0] q[$];
    logic [3:0]    m_flg;
    int            m_cnt[4];
    logic          m_vld;
    logic [1:0]    m_ch;
    logic [OW-1:0] e;

    always #5 clk = ~clk;

    lib_edge_flg_bank #(.NCH(NCH), .SYNC_STAGES(S), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n), .data_i(data_i), .mode_i(mode_i), .clr_i(clr_i),
        .pulse_o(pulse_o), .flg_o(flg_o), .cnt_o(cnt_o), .any_flg_o(any_flg_o),
        .first_vld_o(first_vld_o), .first_ch_o(first_ch_o)
    );

    function automatic logic [OW-1:0] obs();
        return {pulse_o, flg_o, cnt_o, any_flg_o, first_vld_o, first_ch_o};
    endfunction

    task automatic model_reset();
        hist.delete();
        q.delete();
        ecount = 0;
        m_flg  = '0;
        m_vld  = 1'b0;
        m_ch   = '0;
        for (int n = 0; n < NCH; n++) m_cnt[n] = 0;
    endtask

    task automatic do_reset(input logic [3:0] d, input logic [7:0] m);
        reset_n = 1'b0;
        data_i  = d;
        mode_i  = m;
        clr_i   = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // Predict outputs for the coming edge from the history of driven inputs, push, clock, pop
    task automatic tick(output logic [OW-1:0] exp_o);
        logic [3:0]  s, p, ev, fn;
        logic [31:0] c;
        ecount++;
        hist.push_back(data_i);
        s  = (ecount > S)     ? hist[ecount-S-1] : 4'b0;
        p  = (ecount > S + 1) ? hist[ecount-S-2] : 4'b0;
        ev = '0;
        if (ecount > S + 1)
            for (int n = 0; n < NCH; n++)
                case (mode_i[2*n +: 2])
                    2'b01:   ev[n] = !p[n] && s[n];
                    2'b10:   ev[n] = p[n] && !s[n];
                    2'b11:   ev[n] = p[n] != s[n];
                    default: ev[n] = 1'b0;
                endcase
        fn = ev | (m_flg & ~clr_i);
        for (int n = 0; n < NCH; n++)
            if (clr_i[n]) m_cnt[n] = ev[n] ? 1 : 0;
            else if (ev[n] && m_cnt[n] < 255) m_cnt[n]++;
        if (fn == 4'b0) m_vld = 1'b0;
        else if (!m_vld && ev != 4'b0) begin
            m_vld = 1'b1;
            for (int n = NCH - 1; n >= 0; n--) if (ev[n]) m_ch = 2'(n);
        end
        m_flg = fn;
        for (int n = 0; n < NCH; n++) c[n*CW +: CW] = 8'(m_cnt[n]);
        q.push_back({ev, fn, c, |fn, m_vld, m_ch});
        @(posedge clk);
        #1 exp_o = q.pop_front();
    endtask

    task automatic test_reset();
        do_reset(4'h0, 8'h00);
        total++;
        if (obs() !== '0) begin bad++; $display("FAIL reset_state got=%h exp=0", obs()); end
        for (int i = 0; i < 4; i++) begin
            tick(e); total++;
            if (obs() !== e) begin bad++; $display("FAIL reset_idle got=%h exp=%h", obs(), e); end
        end
    endtask

    task automatic test_rise();
        do_reset(4'h0, 8'h01);
        for (int i = 0; i < 5; i++) begin
            tick(e); total++;
            if (obs() !== e) begin bad++; $display("FAIL rise_warm got=%h exp=%h", obs(), e); end
        end
        data_i[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(e); total++;
            if (obs() !== e) begin bad++; $display("FAIL rise_model got=%h exp=%h", obs(), e); end
            total++;
            if (pulse_o[0] !== (i == 2)) begin bad++; $display("FAIL rise_pulse cyc=%0d got=%b exp=%b", i, pulse_o[0], i == 2); end
        end
        total++;
        if ({flg_o, cnt_o[7:0], first_vld_o, first_ch_o} !== {4'b0001, 8'd1, 1'b1, 2'd0}) begin
            bad++; $display("FAIL rise_state flg=%b cnt=%0d vld=%b ch=%0d exp flg=0001 cnt=1 vld=1 ch=0",
                            flg_o, cnt_o[7:0], first_vld_o, first_ch_o);
        end
    endtask

    task automatic test_high_at_reset();
        do_reset(4'hF, 8'hFF);
        for (int i = 0; i < 10; i++) begin
            tick(e); total++;
            if (obs() !== e) begin bad++; $display("FAIL high_model got=%h exp=%h", obs(), e); end
            total++;
            if ({pulse_o, flg_o, cnt_o} !== 40'h0) begin bad++; $display("FAIL high_quiet got=%h exp=0", {pulse_o, flg_o, cnt_o}); end
        end
        data_i[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(e); total++;
            if (obs() !== e) begin bad++; $display("FAIL high_toggle got=%h exp=%h", obs(), e); end
        end
        total++;
        if ({flg_o, first_ch_o, cnt_o[15:8]} !== {4'b0010, 2'd1, 8'd1}) begin
            bad++; $display("FAIL high_fall flg=%b ch=%0d cnt1=%0d exp flg=0010 ch=1 cnt1=1", flg_o, first_ch_o, cnt_o[15:8]);
        end
    endtask

    task automatic test_saturate();
        int np;
        np = 0;
        do_reset(4'h0, 8'h30);
        for (int i = 0; i < 4; i++) tick(e);
        for (int i = 0; i < 303; i++) begin
            if (i < 300) data_i[2] = ~data_i[2];
            tick(e); total++;
            if (obs() !== e) begin bad++; $display("FAIL sat_model cyc=%0d got=%h exp=%h", i, obs(), e); end
            np += int'(pulse_o[2]);
        end
        total++;
        if (np !== 300) begin bad++; $display("FAIL sat_pulses got=%0d exp=300", np); end
        for (int i = 0; i < 3; i++) begin
            data_i[2] = ~data_i[2];
            tick(e); total++;
            if (cnt_o[23:16] !== 8'd255) begin bad++; $display("FAIL sat_hold got=%0d exp=255", cnt_o[23:16]); end
        end
    endtask

    task automatic test_first();
        do_reset(4'h0, 8'h55);
        for (int i = 0; i < 4; i++) tick(e);
        data_i = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            tick(e); total++;
            if (obs() !== e) begin bad++; $display("FAIL first_model got=%h exp=%h", obs(), e); end
        end
        total++;
        if ({first_vld_o, first_ch_o, flg_o} !== {1'b1, 2'd1, 4'b1010}) begin
            bad++; $display("FAIL first_tie vld=%b ch=%0d flg=%b exp vld=1 ch=1 flg=1010", first_vld_o, first_ch_o, flg_o);
        end
        data_i[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(e); total++;
            if (obs() !== e) begin bad++; $display("FAIL first_later got=%h exp=%h", obs(), e); end
        end
        total++;
        if ({first_ch_o, flg_o} !== {2'd1, 4'b1011}) begin
            bad++; $display("FAIL first_hold ch=%0d flg=%b exp ch=1 flg=1011", first_ch_o, flg_o);
        end
        clr_i = 4'hF;
        tick(e);
        clr_i = 4'h0;
        tick(e); total++;
        if ({flg_o, any_flg_o, first_vld_o, cnt_o} !== 38'h0) begin
            bad++; $display("FAIL first_clear flg=%b any=%b vld=%b cnt=%h exp all 0", flg_o, any_flg_o, first_vld_o, cnt_o);
        end
    endtask

    task automatic test_clr_vs_event();
        data_i[0] = 1'b0;
        for (int i = 0; i < 4; i++) tick(e);
        data_i[0] = 1'b1;
        for (int i = 0; i < 4; i++) tick(e);
        data_i[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(e); total++;
            if (obs() !== e) begin bad++; $display("FAIL clrev_pre got=%h exp=%h", obs(), e); end
        end
        data_i[0] = 1'b1;
        tick(e);
        tick(e);
        clr_i[0] = 1'b1;
        tick(e);
        clr_i[0] = 1'b0;
        total++;
        if (obs() !== e) begin bad++; $display("FAIL clrev_model got=%h exp=%h", obs(), e); end
        total++;
        if ({pulse_o[0], flg_o[0], cnt_o[7:0], first_vld_o} !== {1'b1, 1'b1, 8'd1, 1'b1}) begin
            bad++; $display("FAIL clrev_win pulse=%b flg=%b cnt=%0d vld=%b exp 1 1 1 1", pulse_o[0], flg_o[0], cnt_o[7:0], first_vld_o);
        end
    endtask

    task automatic test_mode_switch();
        int np;
        do_reset(4'h0, 8'h02);
        for (int i = 0; i < 4; i++) tick(e);
        np = 0;
        for (int i = 0; i < 8; i++) begin
            data_i[0] = (i < 4);
            tick(e); total++;
            if (obs() !== e) begin bad++; $display("FAIL mode10_model got=%h exp=%h", obs(), e); end
            np += int'(pulse_o[0]);
        end
        total++;
        if (np !== 1) begin bad++; $display("FAIL mode10_pulses got=%0d exp=1", np); end
        mode_i = 8'h00;
        np = 0;
        for (int i = 0; i < 8; i++) begin
            data_i[0] = (i < 4);
            tick(e); total++;
            if (obs() !== e) begin bad++; $display("FAIL mode00_model got=%h exp=%h", obs(), e); end
            np += int'(pulse_o[0]);
        end
        total++;
        if (np !== 0) begin bad++; $display("FAIL mode00_pulses got=%0d exp=0", np); end
    endtask

    task automatic test_reset_mid();
        do_reset(4'h0, 8'h03);
        for (int i = 0; i < 12; i++) begin
            data_i[0] = ~data_i[0];
            tick(e); total++;
            if (obs() !== e) begin bad++; $display("FAIL mid_model got=%h exp=%h", obs(), e); end
        end
        reset_n = 1'b0;
        #2 total++;
        if (obs() !== '0) begin bad++; $display("FAIL mid_reset got=%h exp=0", obs()); end
        do_reset(4'h0, 8'h00);
    endtask

    initial begin
        test_reset();
        test_rise();
        test_high_at_reset();
        test_saturate();
        test_first();
        test_clr_vs_event();
        test_mode_switch();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lib_edge_flg_bank.md
Name: lib_edge_flg_bank

Overview:
- Multi-channel, parametrised generalisation of the sticky posedge flag used across the ECG feature extractor.
- Each channel has:
  - an optional input synchroniser
  - selectable edge mode (off / rise / fall / both)
  - a one-cycle event pulse
  - a sticky flag with per-channel clear
  - a saturating event counter
- The block also records which channel flagged first since all flags were last clear.
- Sits between detector outputs (QRS/peak strobes, threshold comparators) and the feature-sequencing FSM.

Parameters:
- NCH, 4, number of channels (1..16).
- SYNC_STAGES, 2, synchroniser flops per channel (0..3); 0 means data_i is used directly and must already be in the clk domain.
- CNT_W, 8, width of each per-channel event counter (2..16).

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- data_i  input  NCH  level inputs, bit n = channel n.
- mode_i  input  2*NCH  edge mode, bits [2n+1:2n] for channel n: 00 off, 01 rise, 10 fall, 11 both.
- clr_i  input  NCH  per-channel synchronous clear of flag and counter.
- pulse_o  output  NCH  one-cycle event strobe per channel.
- flg_o  output  NCH  sticky event flag per channel.
- cnt_o  output  NCH*CNT_W  saturating event count, bits [(n+1)*CNT_W-1:n*CNT_W] for channel n.
- any_flg_o  output  1  OR of flg_o.
- first_vld_o  output  1  first_ch_o holds a valid capture.
- first_ch_o  output  max(1,clog2(NCH))  index of the first channel to flag.

Behaviour:
- Reset values: all outputs 0; synchroniser flops, previous-sample registers and warm-up counter also 0.
- Synchroniser: s[n] is data_i[n] delayed through SYNC_STAGES flops. With SYNC_STAGES=0, s[n] = data_i[n] combinationally.
- Edge detection:
  - prev[n] <= s[n] every cycle.
  - rise = ~prev & s; fall = prev & ~s.
  - ev[n] = primed & ((mode=01 & rise) | (mode=10 & fall) | (mode=11 & (rise|fall))).
  - mode 00 never produces events.
- Warm-up after reset release:
  - primed stays 0 for the first SYNC_STAGES+1 rising clk edges, then stays 1 until the next reset.
  - This suppresses false edges from flushing reset-zero values out of the synchroniser.
  - An input that is already high at reset release gives no rise event.
- Latency: an input transition present before edge k produces pulse_o/flg_o high after edge k+SYNC_STAGES, i.e. SYNC_STAGES+1 cycles, all outputs registered.
- mode_i changes: sampled every cycle, take effect on the same cycle's comparison, no pipeline.
- pulse_o[n] <= ev[n]. Consecutive toggles in mode 11 give pulses on consecutive cycles.
- Flag: flg_o[n] <= ev[n] | (flg_o[n] & ~clr_i[n]).
  - Event wins over a simultaneous clear; the flag stays 1.
- Counter:
  - clr_i[n] & ev[n]: cnt = 1.
  - clr_i[n] alone: cnt = 0.
  - ev[n] alone: cnt+1, saturating at 2^CNT_W-1, never wraps.
- clr_i does not affect pulse_o, prev or the synchroniser.
- any_flg_o: registered, equals the OR of the next-state flags; asserts in the same cycle as the first flg_o bit.
- First-channel capture:
  - If first_vld_o=0 and any ev[n]=1: first_ch_o <= lowest n with ev[n]=1, first_vld_o <= 1.
  - Ties go to the lowest index.
  - While first_vld_o=1, first_ch_o holds.
  - first_vld_o clears in the cycle all next-state flags are 0.
  - If all flags clear and a new event occur in the same cycle, the capture is kept (flag survives).
- Reset mid-operation: all state returns to reset values asynchronously; warm-up restarts on release.

Test Plan:
- SYNC_STAGES=2, ch0 mode 01, data_i[0] 0->1 two cycles after warm-up -> pulse_o[0]=1 for exactly 1 cycle, 3 cycles after the change; flg_o[0]=1 held; cnt=1; first_ch_o=0, first_vld_o=1.
- data_i=all 1 held through reset release, all modes 11 -> no pulse, flag or count during or after warm-up until an input actually toggles.
- ch2 mode 11, toggle data_i[2] every cycle for 300 cycles, CNT_W=8 -> 300 pulses; cnt_o ch2 saturates at 255 and holds.
- ch1 and ch3 edges in the same cycle, all flags initially 0 -> first_ch_o=1; later event on ch0 leaves first_ch_o=1; clr_i=4'b1111 -> flg_o=0, any_flg_o=0, first_vld_o=0, counts 0.
- clr_i[0] asserted in the same cycle as ch0 event -> flg_o[0] stays 1, cnt=1, first_vld_o stays 1.
- ch0 mode 10 then switched to 00 before a falling edge -> a fall under 10 gives a pulse; a fall under 00 gives none. Assert reset_n mid-count -> all outputs 0 immediately.
